uart_rx_os16: RTL and testbench
===============================

Name: uart_rx_os16

Overview:
- 16x-oversampling UART receiver. It sits directly downstream of the baud-rate divider lookup and consumes its 32-bit cfg_divider output.
- Recovers 8N1 frames from the asynchronous serial line and presents each byte on a valid/ready holding register to the terminal input logic.
- Flags framing errors and overruns.
- An all-ones cfg_divider (the lookup's invalid code) disables reception.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- SYNC_STAGES, 2, flops in the rx input synchroniser (minimum 2).

Ports:
- clk  input  1  single system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- cfg_divider  input  32  oversample tick period minus 1. 32'hFFFF_FFFF means disabled.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  received byte, stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full and not being read.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops set to 1, state set to IDLE.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Tick counter and os_cnt cleared.
- rx_s is the rx line after SYNC_STAGES flops. It adds SYNC_STAGES cycles of latency.
- Tick generator:
  - A down-counter reloads with cfg_divider and asserts tick for one cycle when it reaches 0, so one tick every cfg_divider+1 clocks.
  - It is reloaded and os_cnt is zeroed on entry to START.
  - It is held idle in IDLE.
- os_cnt:
  - 4-bit counter, incremented on each tick, wraps 15 to 0.
  - The comparisons below use the pre-increment value.
- Majority vote: sample rx_s on the ticks where os_cnt is 7, 8 and 9. The bit value is the majority (at least 2 of 3).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: if cfg_divider is not all-ones and rx_s==0, go to START.
  - START: on the os_cnt==9 tick, a majority of 1 is a false start and returns to IDLE. A majority of 0 continues. On the os_cnt==15 tick, go to DATA with bit index 0.
  - DATA: on the os_cnt==9 tick, shift the voted bit into the shift register MSB, so the byte is LSB-first. On the os_cnt==15 tick, increment the bit index. After DATA_BITS bits, go to STOP.
  - STOP: decision at the os_cnt==9 tick, not at the end of the bit, so back-to-back frames are caught.
    - Voted 1: deliver the byte, go to IDLE.
    - Voted 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE.
- Delivery (same cycle as the STOP decision):
  - If rx_valid==0, or (rx_valid & rx_ready) in that cycle: load rx_data and set rx_valid=1.
  - Otherwise: pulse overrun. The new byte is dropped and the held byte is unchanged.
- rx_valid clears on (rx_valid & rx_ready) when no delivery happens in the same cycle.
- rx_ready while rx_valid=0 is ignored.
- cfg_divider changes:
  - A change of cfg_divider in any non-IDLE state aborts the frame. The FSM goes to IDLE with no pulses, and the holding register is untouched. Change is detected against a registered copy.
  - cfg_divider all-ones in any state forces IDLE, no ticks.
- cfg_divider=0 is legal: tick every clock.
- Frame timing: the byte is delivered (DATA_BITS+1)*16+10 ticks after start detection, i.e. at the os_cnt==9 tick of the stop bit.

Decomposition:
- Package uart_pkg:
  - rx state enum.
  - OS_RATE=16.
  - SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
  - CFG_DISABLED=32'hFFFF_FFFF.
- One natural sub-module: uart_os_tick_gen (down-counter, reload/clear input, tick output, disabled detection).

Test Plan:
- Frame receive: cfg_divider=26 (115200 at 50 MHz, 432 clocks/bit), send 0xA5 8N1 -> rx_valid=1, rx_data=8'hA5, frame_err=0, overrun=0.
- False start: cfg_divider=2, rx low for 12 clocks then high -> FSM returns to IDLE, rx_valid stays 0, no pulses.
- Framing error: send 0x3C with stop bit low, then rx high -> frame_err pulses once, rx_valid stays 0, next 0x55 frame is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=8'h11, one overrun pulse, rx_valid=1. Then assert rx_ready for one cycle -> rx_valid=0.
- Read/write collision: rx_valid=1 holding 0x11, assert rx_ready in exactly the cycle 0x22 completes -> rx_data=8'h22, rx_valid=1, no overrun.
- Reset and disable:
  - Assert reset mid-DATA -> outputs zero immediately. After release, a fresh 0x7E frame is received.
  - cfg_divider=32'hFFFF_FFFF with 0x7E sent -> nothing received.
  - Changing cfg_divider mid-frame aborts the frame silently.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int          OS_RATE      = 16;
  localparam logic [3:0]  OS_LAST      = 4'(OS_RATE - 1);
  localparam logic [3:0]  SAMPLE_LO    = 4'd7;
  localparam logic [3:0]  SAMPLE_MID   = 4'd8;
  localparam logic [3:0]  SAMPLE_HI    = 4'd9;
  localparam logic [31:0] CFG_DISABLED = 32'hFFFF_FFFF;

  // 2-of-3 majority used for the mid-bit vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one tick every divider+1 clocks, held while
// cleared or when the divider carries the disabled code.
module uart_os_tick_gen
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] divider,
  input  logic        clear,
  output logic        tick,
  output logic        disabled
);

  logic [31:0] cnt_r;
  logic        tick_r;

  assign disabled = (divider == CFG_DISABLED);
  assign tick     = tick_r;

  // Down-counter with reload on terminal count; clear keeps it preloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= 32'h0;
      tick_r <= 1'b0;
    end else if (clear || disabled) begin
      cnt_r  <= divider;
      tick_r <= 1'b0;
    end else if (cnt_r == 32'h0) begin
      cnt_r  <= divider;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r - 32'd1;
      tick_r <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling 8N1 UART receiver with a valid/ready holding register,
// framing-error and overrun pulses.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          cfg_divider,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [31:0]            cfg_div_r;
  rx_state_t              state_r;
  logic [3:0]             os_cnt_r;
  logic [IDX_W-1:0]       bit_idx_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic [1:0]             vote_r;
  logic [DATA_BITS-1:0]   rx_data_r;
  logic                   rx_valid_r;
  logic                   frame_err_r;
  logic                   overrun_r;

  logic rx_s;
  logic tick_s;
  logic disabled_s;
  logic tick_clear_s;
  logic abort_s;
  logic vote_s;
  logic at_hi_s;
  logic at_last_s;
  logic stop_ok_s;
  logic take_s;

  assign rx_s         = sync_r[SYNC_STAGES-1];
  assign tick_clear_s = (state_r == ST_IDLE);
  // A divider change only matters once a frame is under way.
  assign abort_s      = disabled_s || ((state_r != ST_IDLE) && (cfg_divider != cfg_div_r));
  assign vote_s       = maj3(vote_r[0], vote_r[1], rx_s);
  assign at_hi_s      = tick_s && (os_cnt_r == SAMPLE_HI);
  assign at_last_s    = tick_s && (os_cnt_r == OS_LAST);
  assign stop_ok_s    = !abort_s && (state_r == ST_STOP) && at_hi_s && vote_s;
  assign take_s       = rx_valid_r && rx_ready;

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

  uart_os_tick_gen u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .divider  (cfg_divider),
    .clear    (tick_clear_s),
    .tick     (tick_s),
    .disabled (disabled_s)
  );

  // Input synchroniser (idles high) and registered divider copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r    <= {SYNC_STAGES{1'b1}};
      cfg_div_r <= 32'h0;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], rx};
      cfg_div_r <= cfg_divider;
    end
  end

  // Receive FSM, sample voting, holding register and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      os_cnt_r    <= 4'd0;
      bit_idx_r   <= {IDX_W{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      vote_r      <= 2'b00;
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;

      if (tick_s && (os_cnt_r == SAMPLE_LO)) begin
        vote_r[0] <= rx_s;
      end
      if (tick_s && (os_cnt_r == SAMPLE_MID)) begin
        vote_r[1] <= rx_s;
      end

      // A read in the delivery cycle frees the slot for the new byte.
      if (stop_ok_s) begin
        if (!rx_valid_r || rx_ready) begin
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (take_s) begin
        rx_valid_r <= 1'b0;
      end

      if (abort_s) begin
        state_r  <= ST_IDLE;
        os_cnt_r <= 4'd0;
      end else begin
        if (tick_s) begin
          os_cnt_r <= os_cnt_r + 4'd1;
        end
        case (state_r)
          ST_IDLE: begin
            os_cnt_r <= 4'd0;
            if (!rx_s) begin
              state_r <= ST_START;
            end
          end
          ST_START: begin
            if (at_hi_s && vote_s) begin
              state_r <= ST_IDLE;
            end else if (at_last_s) begin
              state_r   <= ST_DATA;
              bit_idx_r <= {IDX_W{1'b0}};
            end
          end
          ST_DATA: begin
            if (at_hi_s) begin
              shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
            end
            if (at_last_s) begin
              if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
                state_r <= ST_STOP;
              end else begin
                bit_idx_r <= bit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
              end
            end
          end
          ST_STOP: begin
            // Decide mid-bit so a start bit right after the stop bit is seen.
            if (at_hi_s) begin
              if (vote_s) begin
                state_r <= ST_IDLE;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            os_cnt_r <= 4'd0;
            if (rx_s) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed scenarios plus randomized
// frames checked against a line-level reference model.
module tb_uart_rx_os16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cfg_divider = 32'd26;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] acc_q[$];

  always #10 clk = ~clk;

  uart_rx_os16 #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cfg_divider(cfg_divider), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  // Pulse counters and consumer-side log, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_q.push_back(rx_data);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Serial line model: an 8N1 frame is {stop, data LSB-first, start=0}.
  function automatic logic [9:0] mk_line(input logic [7:0] b, input logic stop);
    logic [9:0] line;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = b[i];
    line[9] = stop;
    return line;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    logic [9:0] line;
    line = mk_line(b, stop);
    for (int i = 0; i < 10; i++) begin rx = line[i]; cyc(bclk); end
    rx = 1'b1;
  endtask

  task automatic drain;
    rx_ready = 1'b1; cyc(1); rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    checks += 4;
    reset = 1'b0; cyc(5);
  endtask

  task automatic test_frame;
    int f0, o0;
    cfg_divider = 32'd26; cyc(5);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 432); cyc(20);
    checks += 4;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b exp 1", rx_valid); end
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL frame_data got %h exp a5", rx_data); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL frame_ferr got %0d exp %0d", ferr_cnt, f0); end
    if (ovr_cnt != o0) begin errors++; $display("FAIL frame_ovr got %0d exp %0d", ovr_cnt, o0); end
    drain;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_read got %b exp 0", rx_valid); end
  endtask

  task automatic test_false_start;
    int f0, o0;
    cfg_divider = 32'd2; cyc(5);
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0; cyc(12); rx = 1'b1; cyc(200);
    checks += 3;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL fstart_valid got %b exp 0", rx_valid); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL fstart_ferr got %0d exp %0d", ferr_cnt, f0); end
    if (ovr_cnt != o0) begin errors++; $display("FAIL fstart_ovr got %0d exp %0d", ovr_cnt, o0); end
    send_frame(8'h5A, 1'b1, 48); cyc(10);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
      errors++; $display("FAIL fstart_next got %b/%h exp 1/5a", rx_valid, rx_data);
    end
    drain;
  endtask

  task automatic test_frame_err;
    int f0;
    cfg_divider = 32'd3; cyc(5);
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 64); cyc(64);
    checks += 2;
    if (ferr_cnt != f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", ferr_cnt, f0 + 1); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b exp 0", rx_valid); end
    send_frame(8'h55, 1'b1, 64); cyc(10);
    checks += 2;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      errors++; $display("FAIL ferr_next got %b/%h exp 1/55", rx_valid, rx_data);
    end
    if (ferr_cnt != f0 + 1) begin errors++; $display("FAIL ferr_once got %0d exp %0d", ferr_cnt, f0 + 1); end
    drain;
  endtask

  task automatic test_overrun;
    int o0;
    cfg_divider = 32'd3; rx_ready = 1'b0; cyc(5);
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 64); cyc(20);
    send_frame(8'h22, 1'b1, 64); cyc(20);
    checks += 3;
    if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rx_valid); end
    if (ovr_cnt != o0 + 1) begin errors++; $display("FAIL ovr_pulse got %0d exp %0d", ovr_cnt, o0 + 1); end
    drain;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_read got %b exp 0", rx_valid); end
  endtask

  task automatic test_collision;
    int lat, lo, o0;
    cfg_divider = 32'd3; cyc(10);
    lat = -1;
    lo = 154 * 4 + 2;
    fork
      send_frame(8'h11, 1'b1, 64);
      begin
        for (int i = 1; i <= 1000; i++) begin
          cyc(1);
          if (lat < 0 && rx_valid === 1'b1) lat = i;
        end
      end
    join
    checks++;
    if (lat < lo || lat > lo + 4) begin
      errors++; $display("FAIL frame_latency got %0d exp %0d..%0d", lat, lo, lo + 4);
      lat = lo + 2;
    end
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1, 64);
      begin cyc(lat - 1); rx_ready = 1'b1; cyc(1); rx_ready = 1'b0; end
    join
    cyc(20);
    checks += 3;
    if (rx_data !== 8'h22) begin errors++; $display("FAIL coll_data got %h exp 22", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL coll_valid got %b exp 1", rx_valid); end
    if (ovr_cnt != o0) begin errors++; $display("FAIL coll_ovr got %0d exp %0d", ovr_cnt, o0); end
    drain;
  endtask

  task automatic test_reset_mid;
    cfg_divider = 32'd3; cyc(5);
    send_frame(8'h42, 1'b1, 64); cyc(10);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", rx_valid); end
    fork
      send_frame(8'h7E, 1'b1, 64);
      begin
        cyc(64 * 4); reset = 1'b1; #1;
        checks += 3;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", rx_valid); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h exp 00", rx_data); end
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++; $display("FAIL rmid_pulses got %b%b exp 00", frame_err, overrun);
        end
      end
    join
    cyc(5); reset = 1'b0; cyc(5);
    send_frame(8'h7E, 1'b1, 64); cyc(10);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
      errors++; $display("FAIL rmid_next got %b/%h exp 1/7e", rx_valid, rx_data);
    end
    drain;
  endtask

  task automatic test_disable;
    int f0, o0;
    cfg_divider = 32'hFFFF_FFFF; cyc(5);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h7E, 1'b1, 64); cyc(64);
    checks += 2;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %b exp 0", rx_valid); end
    if (ferr_cnt != f0 || ovr_cnt != o0) begin
      errors++; $display("FAIL dis_pulses got %0d/%0d exp %0d/%0d", ferr_cnt, ovr_cnt, f0, o0);
    end
    cfg_divider = 32'd3; cyc(5);
  endtask

  task automatic test_div_change;
    int f0, o0;
    cfg_divider = 32'd3; rx_ready = 1'b0; cyc(5);
    send_frame(8'h99, 1'b1, 64); cyc(10);
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 64);
      begin cyc(64 * 3); cfg_divider = 32'd4; end
    join
    cyc(200);
    checks += 3;
    if (rx_valid !== 1'b1 || rx_data !== 8'h99) begin
      errors++; $display("FAIL chg_hold got %b/%h exp 1/99", rx_valid, rx_data);
    end
    if (ovr_cnt != o0) begin errors++; $display("FAIL chg_ovr got %0d exp %0d", ovr_cnt, o0); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL chg_ferr got %0d exp %0d", ferr_cnt, f0); end
    drain;
    cfg_divider = 32'd3; cyc(5);
  endtask

  task automatic test_random;
    int d, bclk, n0, f0;
    logic [7:0] b;
    logic stop;
    logic [9:0] line;
    rx_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 4);
      cfg_divider = 32'(d); cyc(5);
      bclk = 16 * (d + 1);
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      line = mk_line(b, stop);
      n0 = acc_q.size(); f0 = ferr_cnt;
      send_frame(b, stop, bclk); cyc(bclk);
      checks += 2;
      if (line[9]) begin
        if (acc_q.size() != n0 + 1 || acc_q[acc_q.size() - 1] !== line[8:1]) begin
          errors++; $display("FAIL rand_byte got n=%0d exp n=%0d byte %h", acc_q.size(), n0 + 1, line[8:1]);
        end
        if (ferr_cnt != f0) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", ferr_cnt, f0); end
      end else begin
        if (acc_q.size() != n0) begin errors++; $display("FAIL rand_drop got %0d exp %0d", acc_q.size(), n0); end
        if (ferr_cnt != f0 + 1) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", ferr_cnt, f0 + 1); end
      end
    end
    rx_ready = 1'b0;
  endtask

  initial begin
    cyc(3);
    test_reset;
    test_frame;
    test_false_start;
    test_frame_err;
    test_overrun;
    test_collision;
    test_reset_mid;
    test_disable;
    test_div_change;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
